// File: rtl/dout_serial_tx_pkg.sv
// Shared definitions for the DOUT serial transmitter: register bit positions,
// default flag positions and the frame state encoding.
package dout_serial_tx_pkg;

    // Position of the transmit-request bit inside GOUT.
    localparam int DVAL_BIT = 7;

    // Default flag bus positions for frame completion and dropped requests.
    localparam int FLAG_TXDONE = 0;
    localparam int FLAG_TXOVR  = 1;

    // Frame states, 2-bit encoded.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Serial line level for a given state: start low, data from the shift
    // register, idle and stop high.
    function automatic logic line_level(input tx_state_e st, input logic data_bit);
        logic lvl;
        lvl = 1'b1;
        case (st)
            TX_START: lvl = 1'b0;
            TX_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/dout_serial_tx_bit_timer.sv
// Bit period timer: counts clock cycles within one serial bit and flags the
// last cycle of each bit period.
module dout_serial_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt_q;
    logic [CNT_W-1:0] clk_cnt_d;

    assign bit_end = enable && (clk_cnt_q == LAST);

    // Next count: clear wins, otherwise count while enabled and wrap at the
    // end of the bit period.
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        if (clear) begin
            clk_cnt_d = '0;
        end else if (enable) begin
            if (bit_end) begin
                clk_cnt_d = '0;
            end else begin
                clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
        end
    end

endmodule

// File: rtl/dout_serial_tx.sv
// Serial transmitter for the DOUT special register. A rising edge of the
// GOUT dval bit starts a start/8-data/stop frame carrying the DOUT byte,
// LSB first. Completion and dropped requests are reported as one-cycle
// pulses on flag_out. tx, busy and flag_out are all registered and computed
// from the next state, so they change on the same edge as the FSM.
module dout_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DONE_BIT     = dout_serial_tx_pkg::FLAG_TXDONE,
    parameter int OVR_BIT      = dout_serial_tx_pkg::FLAG_TXOVR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] reg_gout,
    input  logic [7:0] reg_dout,
    output logic       tx,
    output logic       busy,
    output logic [7:0] flag_out,
    output logic [1:0] dbg_state
);

    import dout_serial_tx_pkg::*;

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       dval_q, dval_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic [7:0] flag_q, flag_d;

    logic       request;
    logic       bit_end;
    logic       tmr_clear;
    logic       tmr_enable;
    logic       unused_gout;

    // Only dval is meaningful in GOUT; the remaining bits are deliberately ignored.
    assign unused_gout = ^reg_gout[6:0];

    // A request is a genuine 0->1 edge of dval; dval_q resets high so a level
    // held through reset is not mistaken for an edge.
    assign dval_d  = reg_gout[DVAL_BIT];
    assign request = reg_gout[DVAL_BIT] & ~dval_q;

    assign tmr_enable = (state_q != TX_IDLE);
    assign tmr_clear  = (state_q == TX_IDLE) && request;

    dout_serial_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .bit_end (bit_end)
    );

    // Next-state, shift register, flag pulses and registered output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        flag_d    = '0;

        case (state_q)
            TX_IDLE: begin
                if (request) begin
                    shift_d   = reg_dout;
                    bit_cnt_d = 3'd0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d          = TX_IDLE;
                    flag_d[DONE_BIT] = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // A request while a frame is running is dropped and reported.
        if (request && (state_q != TX_IDLE)) begin
            flag_d[OVR_BIT] = 1'b1;
        end

        tx_d   = line_level(state_d, shift_d[0]);
        busy_d = (state_d != TX_IDLE);
    end

    // State and output registers; reset aborts any frame without flag pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            dval_q    <= 1'b1;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            flag_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dval_q    <= dval_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            flag_q    <= flag_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign flag_out  = flag_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dout_serial_tx.sv
// Bench for dout_serial_tx with CLKS_PER_BIT=4, DONE_BIT=3, OVR_BIT=5.
// Expected bytes and start cycles are queued when a dval edge is driven; a
// line monitor pops them when a frame starts and checks every tx cycle.
module tb_dout_serial_tx;

    localparam int C  = 4;
    localparam int DB = 3;
    localparam int OB = 5;
    localparam logic [7:0] FLAG_OK = 8'h28;

    logic       clk;
    logic       reset;
    logic [7:0] reg_gout;
    logic [7:0] reg_dout;
    logic       tx;
    logic       busy;
    logic [7:0] flag_out;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    bit mon_en = 0;
    int done_cnt = 0;
    int ovr_cnt  = 0;
    int busy_cnt = 0;
    int done_exp = 0;

    dout_serial_tx #(
        .CLKS_PER_BIT(C),
        .DONE_BIT    (DB),
        .OVR_BIT     (OB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_gout  (reg_gout),
        .reg_dout  (reg_dout),
        .tx        (tx),
        .busy      (busy),
        .flag_out  (flag_out),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drop dval for one cycle, then raise it with the new byte. Returns at the
    // negedge of the cycle in which the frame should be starting.
    task automatic send_req(input logic [7:0] b);
        reg_gout[7] = 1'b0;
        reg_gout[6:0] = 7'($urandom_range(0, 127));
        tick(1);
        reg_dout    = b;
        reg_gout[7] = 1'b1;
        exp_q.push_back(b);
        start_q.push_back(cyc + 1);
        done_exp++;
        tick(1);
    endtask

    // One frame seen on the line, starting at the current negedge (tx low).
    task automatic mon_frame();
        logic [7:0] b;
        logic [9:0] fr;
        int st;
        int k;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_frame", 32'd1, 32'd0);
            b  = 8'h00;
            st = cyc;
        end else begin
            b  = exp_q.pop_front();
            st = start_q.pop_front();
        end
        check_eq("start_cycle", cyc, st);
        fr = {1'b1, b, 1'b0};
        k  = 0;
        forever begin
            if (reset) return;
            if (k == 10 * C) begin
                check_eq("done_pulse", {31'd0, flag_out[DB]}, 32'd1);
                check_eq("busy_after", {31'd0, busy}, 32'd0);
                check_eq("tx_after", {31'd0, tx}, 32'd1);
                return;
            end
            check_eq("tx_bit", {31'd0, tx}, {31'd0, fr[k / C]});
            check_eq("busy_frame", {31'd0, busy}, 32'd1);
            @(negedge clk);
            k++;
        end
    endtask

    // line monitor
    initial begin
        forever begin
            @(negedge clk);
            while (mon_en && !reset && tx === 1'b0) mon_frame();
        end
    end

    // flag bus monitor: only DONE_BIT/OVR_BIT may ever pulse
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("flag_bits", {24'd0, flag_out & ~FLAG_OK}, 32'd0);
            if (flag_out[DB] === 1'b1) done_cnt++;
            if (flag_out[OB] === 1'b1) ovr_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // watchdog
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, o0, b0;
        logic [7:0] rb;

        // reset with dval held high
        reset    = 1'b1;
        reg_gout = 8'h80;
        reg_dout = 8'h00;
        tick(1);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_flag", {24'd0, flag_out}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        tick(2);
        reset  = 1'b0;
        mon_en = 1;
        tick(20);
        check_eq("held_dval_busy", {31'd0, busy}, 32'd0);
        check_eq("held_dval_tx", {31'd0, tx}, 32'd1);

        // basic frame
        send_req(8'hA5);
        tick(44);

        // overrun during a frame
        d0 = done_cnt; o0 = ovr_cnt;
        send_req(8'h3C);
        tick(8);
        reg_gout[7] = 1'b0;
        tick(2);
        reg_gout[7] = 1'b1;
        tick(1);
        check_eq("ovr_pulse", {31'd0, flag_out[OB]}, 32'd1);
        tick(1);
        check_eq("ovr_one_cycle", {31'd0, flag_out[OB]}, 32'd0);
        tick(32);
        check_eq("ovr_count", ovr_cnt - o0, 32'd1);
        check_eq("ovr_done_count", done_cnt - d0, 32'd1);

        // DOUT changes mid-frame
        send_req(8'h81);
        tick(10);
        reg_dout = 8'hFF;
        tick(34);

        // back-to-back: second edge driven in the DONE cycle
        d0 = done_cnt; o0 = ovr_cnt; b0 = busy_cnt;
        send_req(8'h5A);
        tick(39);
        reg_gout[7] = 1'b0;
        tick(1);
        check_eq("b2b_done_cycle", {31'd0, flag_out[DB]}, 32'd1);
        reg_dout    = 8'h00;
        reg_gout[7] = 1'b1;
        exp_q.push_back(8'h00);
        start_q.push_back(cyc + 1);
        done_exp++;
        tick(44);
        check_eq("b2b_busy_span", busy_cnt - b0, 32'd80);
        check_eq("b2b_no_ovr", ovr_cnt - o0, 32'd0);
        check_eq("b2b_done_count", done_cnt - d0, 32'd2);

        // reset at cycle 20 of a frame, dval stays high afterwards
        send_req(8'h96);
        done_exp--;
        d0 = done_cnt; o0 = ovr_cnt;
        tick(19);
        reset = 1'b1;
        tick(1);
        check_eq("abort_tx", {31'd0, tx}, 32'd1);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_flag", {24'd0, flag_out}, 32'd0);
        check_eq("abort_state", {30'd0, dbg_state}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(20);
        check_eq("abort_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_no_done", done_cnt - d0, 32'd0);
        check_eq("abort_no_ovr", ovr_cnt - o0, 32'd0);

        // random bytes
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_req(rb);
            tick(42);
        end

        tick(4);
        check_eq("queue_empty", exp_q.size(), 32'd0);
        check_eq("done_total", done_cnt, done_exp);
        check_eq("ovr_total", ovr_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
